// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: iterator state encoding, subsample step
// codes and bounding-box index constants.
package rast_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } iter_state_e;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    localparam int LL = 0;
    localparam int UR = 1;
    localparam int X  = 0;
    localparam int Y  = 1;

    // Right-shift applied to one pixel to get the sample step; an illegal
    // code falls back to one sample per pixel.
    function automatic logic [1:0] step_shift(input logic [3:0] ss);
        case (ss)
            SS_4X:   return 2'd1;
            SS_16X:  return 2'd2;
            SS_64X:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sample_iter_lane_gen.sv
// Combinational lane generator: SAMPS x-adjacent sample positions starting at
// cur_x, each flagged valid when it lies at or left of the box's right edge.
module sample_iter_lane_gen #(
    parameter int SIGFIG = 24,
    parameter int SAMPS  = 4
) (
    input  logic [SIGFIG-1:0]            cur_x,
    input  logic [SIGFIG-1:0]            step,
    input  logic [SIGFIG-1:0]            ur_x,
    output logic [SAMPS-1:0][SIGFIG-1:0] lane_x,
    output logic [SAMPS-1:0]             lane_valid
);

    logic signed [SIGFIG:0] acc;
    logic signed [SIGFIG:0] ur_w;
    logic signed [SIGFIG:0] step_w;

    // One extra bit keeps lanes past the screen edge from wrapping back inside.
    always_comb begin
        ur_w       = $signed({ur_x[SIGFIG-1], ur_x});
        step_w     = $signed({step[SIGFIG-1], step});
        acc        = $signed({cur_x[SIGFIG-1], cur_x});
        lane_x     = '0;
        lane_valid = '0;
        for (int i = 0; i < SAMPS; i++) begin
            lane_x[i]     = acc[SIGFIG-1:0];
            lane_valid[i] = (acc <= ur_w);
            acc           = acc + step_w;
        end
    end

endmodule

// File: rtl/sample_iterator.sv
// Walks a triangle's bounding box in raster order, emitting SAMPS samples per
// cycle. Define SAMPLE_ITERATOR_STATS_EN to add triangle/sample counters.
module sample_iterator
    import rast_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]                 color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                          validTri_R13H,
    input  logic [3:0]                                    subSample_RnnU,
    output logic                                          halt_R13L,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]                 color_R14U,
    output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S,
    output logic [SAMPS-1:0]                              validSamp_R14H
`ifdef SAMPLE_ITERATOR_STATS_EN
    ,
    output logic [31:0]                                   triCount_RnnU,
    output logic [31:0]                                   sampCount_RnnU
`endif
);

    typedef logic signed [SIGFIG:0] wide_t;

    function automatic wide_t sx(input logic [SIGFIG-1:0] v);
        return $signed({v[SIGFIG-1], v});
    endfunction

    iter_state_e state_q, state_d;
    logic [SIGFIG-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
    logic [SIGFIG-1:0] step_q, step_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0] color_q, color_d;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0] sample_q, sample_d;
    logic [SAMPS-1:0] valid_q, valid_d;

    logic [SIGFIG-1:0] in_step;
    logic [SIGFIG-1:0] gen_x, gen_y, gen_step, gen_ur_x;
    logic [SAMPS-1:0][SIGFIG-1:0] lane_x;
    logic [SAMPS-1:0] lane_valid;
    logic emit, accept;
    wide_t span, nx, ny;

    assign in_step = SIGFIG'((32'd1 << RADIX) >> step_shift(subSample_RnnU));

    sample_iter_lane_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_lane_gen (
        .cur_x      (gen_x),
        .step       (gen_step),
        .ur_x       (gen_ur_x),
        .lane_x     (lane_x),
        .lane_valid (lane_valid)
    );

    // The group registered at each edge is the one at cur_d, so the first
    // group is computed straight from the incoming box on accept.
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        ll_x_d   = ll_x_q;
        ur_x_d   = ur_x_q;
        ur_y_d   = ur_y_q;
        step_d   = step_q;
        tri_d    = tri_q;
        color_d  = color_q;
        accept   = 1'b0;
        emit     = 1'b0;
        gen_x    = cur_x_q;
        gen_y    = cur_y_q;
        gen_step = step_q;
        gen_ur_x = ur_x_q;
        span     = wide_t'(SAMPS) * sx(step_q);
        nx       = sx(cur_x_q) + span;
        ny       = sx(cur_y_q) + sx(step_q);
        case (state_q)
            ST_WAIT: begin
                if (validTri_R13H) begin
                    accept  = 1'b1;
                    tri_d   = tri_R13S;
                    color_d = color_R13U;
                    ll_x_d  = box_R13S[LL][X];
                    ur_x_d  = box_R13S[UR][X];
                    ur_y_d  = box_R13S[UR][Y];
                    step_d  = in_step;
                    if (sx(box_R13S[UR][X]) >= sx(box_R13S[LL][X]) &&
                        sx(box_R13S[UR][Y]) >= sx(box_R13S[LL][Y])) begin
                        state_d  = ST_TEST;
                        cur_x_d  = box_R13S[LL][X];
                        cur_y_d  = box_R13S[LL][Y];
                        gen_x    = box_R13S[LL][X];
                        gen_y    = box_R13S[LL][Y];
                        gen_step = in_step;
                        gen_ur_x = box_R13S[UR][X];
                        emit     = 1'b1;
                    end
                end
            end
            ST_TEST: begin
                if (nx <= sx(ur_x_q)) begin
                    cur_x_d = nx[SIGFIG-1:0];
                    emit    = 1'b1;
                end else if (ny <= sx(ur_y_q)) begin
                    cur_x_d = ll_x_q;
                    cur_y_d = ny[SIGFIG-1:0];
                    emit    = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
                gen_x = cur_x_d;
                gen_y = cur_y_d;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        valid_d  = '0;
        sample_d = sample_q;
        if (emit) begin
            valid_d = lane_valid;
            for (int i = 0; i < SAMPS; i++) begin
                sample_d[X][i] = lane_x[i];
                sample_d[Y][i] = gen_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            ll_x_q   <= '0;
            ur_x_q   <= '0;
            ur_y_q   <= '0;
            step_q   <= '0;
            tri_q    <= '0;
            color_q  <= '0;
            sample_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            ll_x_q   <= ll_x_d;
            ur_x_q   <= ur_x_d;
            ur_y_q   <= ur_y_d;
            step_q   <= step_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign halt_R13L      = (state_q == ST_WAIT);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

`ifdef SAMPLE_ITERATOR_STATS_EN
    logic [31:0] tri_cnt_q, tri_cnt_d, samp_cnt_q, samp_cnt_d, lane_cnt;

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < SAMPS; i++) begin
            lane_cnt = lane_cnt + 32'(valid_d[i]);
        end
        tri_cnt_d  = tri_cnt_q + 32'(accept);
        samp_cnt_d = samp_cnt_q + lane_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_cnt_q  <= '0;
            samp_cnt_q <= '0;
        end else begin
            tri_cnt_q  <= tri_cnt_d;
            samp_cnt_q <= samp_cnt_d;
        end
    end

    assign triCount_RnnU  = tri_cnt_q;
    assign sampCount_RnnU = samp_cnt_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: directed boxes from the test plan
// plus randomized boxes checked against a raster-walk reference model.
`timescale 1ns/1ps
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int SAMPS  = 4;
    localparam int PX     = 1 << RADIX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S = '0;
    logic [COLORS-1:0][SIGFIG-1:0] color_R13U = '0;
    logic signed [1:0][1:0][SIGFIG-1:0] box_R13S = '0;
    logic validTri_R13H = 1'b0;
    logic [3:0] subSample_RnnU = 4'b1000;
    logic halt_R13L;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0] color_R14U;
    logic signed [1:0][SAMPS-1:0][SIGFIG-1:0] sample_R14S;
    logic [SAMPS-1:0] validSamp_R14H;
`ifdef SAMPLE_ITERATOR_STATS_EN
    logic [31:0] triCount_RnnU, sampCount_RnnU;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    longint exp_tri_cnt  = 0;
    longint exp_samp_cnt = 0;
    logic [2*SIGFIG+SAMPS-1:0] exp_q[$];

    sample_iterator dut (
        .clk            (clk),
        .rst            (rst),
        .tri_R13S       (tri_R13S),
        .color_R13U     (color_R13U),
        .box_R13S       (box_R13S),
        .validTri_R13H  (validTri_R13H),
        .subSample_RnnU (subSample_RnnU),
        .halt_R13L      (halt_R13L),
        .tri_R14S       (tri_R14S),
        .color_R14U     (color_R14U),
        .sample_R14S    (sample_R14S),
        .validSamp_R14H (validSamp_R14H)
`ifdef SAMPLE_ITERATOR_STATS_EN
        ,
        .triCount_RnnU  (triCount_RnnU),
        .sampCount_RnnU (sampCount_RnnU)
`endif
    );

    always #5 clk = ~clk;

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b0100: return PX / 2;
            4'b0010: return PX / 4;
            4'b0001: return PX / 8;
            default: return PX;
        endcase
    endfunction

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
    endtask

    task automatic rand_payload();
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'($urandom);
    endtask

    task automatic check_idle(input string nm);
        n_tests++;
        if (validSamp_R14H !== '0 || halt_R13L !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: valid=%b halt=%b required valid=0 halt=1", nm, validSamp_R14H, halt_R13L);
        end
    endtask

    // Reference: every sample row from ll_y to ur_y, groups of SAMPS lanes
    // starting at ll_x, lane valid when it lies inside the box.
    task automatic run_tri(input string nm, input int llx, input int lly,
                           input int urx, input int ury, input logic [3:0] ss);
        int step;
        int k;
        bit first;
        logic [SAMPS-1:0] m;
        logic [SIGFIG-1:0] ex_x, ex_y, lx;
        logic [2*SIGFIG+SAMPS-1:0] e;
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t;
        logic [COLORS-1:0][SIGFIG-1:0] c;
        step = step_of(ss);
        exp_q.delete();
        if (urx >= llx && ury >= lly) begin
            for (longint y = lly; y <= ury; y += step) begin
                for (longint x = llx; x <= urx; x += SAMPS * step) begin
                    for (int i = 0; i < SAMPS; i++) m[i] = (x + i * step <= urx);
                    ex_x = SIGFIG'(x);
                    ex_y = SIGFIG'(y);
                    exp_q.push_back({m, ex_y, ex_x});
                end
            end
        end
        k = 0;
        while (halt_R13L !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (halt_R13L !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: halt=%b required 1", nm, halt_R13L);
        end
        rand_payload();
        t = tri_R13S;
        c = color_R13U;
        set_box(llx, lly, urx, ury);
        subSample_RnnU = ss;
        validTri_R13H = 1'b1;
        @(negedge clk);
        validTri_R13H = 1'b0;
        exp_tri_cnt++;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = e[2*SIGFIG +: SAMPS];
            ex_y = e[SIGFIG +: SIGFIG];
            ex_x = e[0 +: SIGFIG];
            n_tests++;
            if (halt_R13L !== 1'b0 || validSamp_R14H !== m) begin
                n_fail++;
                $display("FAIL %s group y=%0d x=%0d: halt=%b valid=%b required halt=0 valid=%b",
                         nm, $signed(ex_y), $signed(ex_x), halt_R13L, validSamp_R14H, m);
            end
            for (int i = 0; i < SAMPS; i++) begin
                lx = ex_x + SIGFIG'(i * step);
                n_tests++;
                if (sample_R14S[0][i] !== lx || sample_R14S[1][i] !== ex_y) begin
                    n_fail++;
                    $display("FAIL %s lane%0d pos: got (%h,%h) required (%h,%h)",
                             nm, i, sample_R14S[0][i], sample_R14S[1][i], lx, ex_y);
                end
            end
            if (first) begin
                n_tests++;
                if (tri_R14S !== t || color_R14U !== c) begin
                    n_fail++;
                    $display("FAIL %s payload: tri=%h color=%h required tri=%h color=%h",
                             nm, tri_R14S, color_R14U, t, c);
                end
                first = 1'b0;
            end
            for (int i = 0; i < SAMPS; i++) exp_samp_cnt += m[i];
            @(negedge clk);
        end
        check_idle(nm);
    endtask

    task automatic check_stats(input string nm);
`ifdef SAMPLE_ITERATOR_STATS_EN
        n_tests++;
        if (triCount_RnnU !== exp_tri_cnt[31:0] || sampCount_RnnU !== exp_samp_cnt[31:0]) begin
            n_fail++;
            $display("FAIL %s stats: tri=%0d samp=%0d required tri=%0d samp=%0d",
                     nm, triCount_RnnU, sampCount_RnnU, exp_tri_cnt[31:0], exp_samp_cnt[31:0]);
        end
`else
        if (nm.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_tri_cnt = 0;
        exp_samp_cnt = 0;
        @(negedge clk);
        n_tests++;
        if (halt_R13L !== 1'b1 || validSamp_R14H !== '0 || sample_R14S !== '0 ||
            tri_R14S !== '0 || color_R14U !== '0) begin
            n_fail++;
            $display("FAIL reset: halt=%b valid=%b sample=%h tri=%h color=%h required 1/0/0/0/0",
                     halt_R13L, validSamp_R14H, sample_R14S, tri_R14S, color_R14U);
        end
        check_stats("reset");
    endtask

    task automatic test_full_box();
        run_tri("full_4x2", 0, 0, 3 * PX, PX, 4'b1000);
    endtask

    task automatic test_partial_row();
        run_tri("partial_row", 0, 0, PX, 0, 4'b1000);
    endtask

    task automatic test_msaa();
        run_tri("msaa4", 0, 0, PX / 2, PX / 2, 4'b0100);
        run_tri("msaa16", -PX, PX, PX, 2 * PX, 4'b0010);
        run_tri("msaa64", 0, 0, PX, PX / 2, 4'b0001);
    endtask

    task automatic test_degenerate();
        run_tri("degenerate_x", 2 * PX, 0, PX, 0, 4'b1000);
        run_tri("degenerate_y", 0, 2 * PX, PX, PX, 4'b0100);
        check_stats("degenerate");
    endtask

    task automatic test_back_to_back();
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tb_t;
        @(negedge clk);
        rand_payload();
        set_box(0, 0, PX, 0);
        subSample_RnnU = 4'b1000;
        validTri_R13H = 1'b1;
        @(negedge clk);
        n_tests++;
        if (validSamp_R14H !== 4'b0011 || halt_R13L !== 1'b0 || sample_R14S[0][1] !== SIGFIG'(PX)) begin
            n_fail++;
            $display("FAIL b2b first: valid=%b halt=%b x1=%h required 0011/0/%h",
                     validSamp_R14H, halt_R13L, sample_R14S[0][1], SIGFIG'(PX));
        end
        rand_payload();
        tb_t = tri_R13S;
        set_box(2 * PX, PX, 2 * PX, PX);
        @(negedge clk);
        check_idle("b2b_bubble");
        @(negedge clk);
        validTri_R13H = 1'b0;
        n_tests++;
        if (validSamp_R14H !== 4'b0001 || sample_R14S[0][0] !== SIGFIG'(2 * PX) ||
            sample_R14S[1][0] !== SIGFIG'(PX) || tri_R14S !== tb_t) begin
            n_fail++;
            $display("FAIL b2b second: valid=%b x=%h y=%h required 0001/%h/%h",
                     validSamp_R14H, sample_R14S[0][0], sample_R14S[1][0], SIGFIG'(2 * PX), SIGFIG'(PX));
        end
        exp_tri_cnt += 2;
        exp_samp_cnt += 3;
        @(negedge clk);
        check_idle("b2b_end");
        check_stats("b2b");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rand_payload();
        set_box(0, 0, PX, 2 * PX);
        subSample_RnnU = 4'b1000;
        validTri_R13H = 1'b1;
        @(negedge clk);
        validTri_R13H = 1'b0;
        @(negedge clk);
        n_tests++;
        if (validSamp_R14H !== 4'b0011 || sample_R14S[1][0] !== SIGFIG'(PX)) begin
            n_fail++;
            $display("FAIL rst_mid row2: valid=%b y=%h required 0011/%h",
                     validSamp_R14H, sample_R14S[1][0], SIGFIG'(PX));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_tri_cnt = 0;
        exp_samp_cnt = 0;
        n_tests++;
        if (validSamp_R14H !== '0 || halt_R13L !== 1'b1 || sample_R14S !== '0 ||
            tri_R14S !== '0 || color_R14U !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b halt=%b sample=%h required 0/1/0",
                     validSamp_R14H, halt_R13L, sample_R14S);
        end
        check_stats("rst_mid");
        run_tri("after_rst", PX, PX, 3 * PX, PX, 4'b1000);
    endtask

    task automatic test_random();
        int llx, lly, w, h;
        logic [3:0] ss;
        for (int n = 0; n < 40; n++) begin
            ss = 4'b1000 >> $urandom_range(0, 3);
            w = $urandom_range(0, 4);
            h = $urandom_range(0, 3);
            llx = (int'($urandom_range(0, 11)) - 3) * PX;
            lly = (int'($urandom_range(0, 11)) - 3) * PX;
            if ($urandom_range(0, 5) == 0) llx = (8191 - w) * PX;
            if ($urandom_range(0, 7) == 0) w = -1;
            run_tri("random", llx, lly, llx + w * PX, lly + h * PX, ss);
        end
        check_stats("random");
    endtask

    initial begin
        test_reset();
        test_full_box();
        test_partial_row();
        test_msaa();
        test_degenerate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Producer side of the sample-test interface. Accepts one triangle plus its pixel-aligned bounding box from the bounding-box stage.
- Walks the box in raster order at the current subsample step, emitting SAMPS horizontally adjacent sample locations per cycle, together with the triangle and color, toward hash-jitter/sampletest.
- Stalls the upstream stage while a box is being iterated.

Parameters:
- SIGFIG, 24, bits in position/color
- RADIX, 10, fraction bits (1 pixel = 1<<RADIX)
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- SAMPS, 4, samples emitted per cycle (lanes, x-adjacent)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tri_R13S  in  signed SIGFIG [VERTS][AXIS]  input triangle
- color_R13U  in  SIGFIG [COLORS]  triangle color
- box_R13S  in  signed SIGFIG [2][2]  [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y; grid-aligned
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnU  in  4  one-hot step: 1000=1/px, 0100=4, 0010=16, 0001=64 samples/px
- halt_R13L  out  1  1=ready to accept; 0=stall upstream
- tri_R14S  out  signed SIGFIG [VERTS][AXIS]  held triangle
- color_R14U  out  SIGFIG [COLORS]  held color
- sample_R14S  out  signed SIGFIG [2][SAMPS]  sample x/y per lane
- validSamp_R14H  out  1 [SAMPS]  lane valid

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Step: step = 1<<RADIX, >>1, >>2, >>3 for the four subSample codes. subSample is sampled at triangle accept and held for that triangle.
- FSM states: WAIT, TEST.
- halt_R13L = (state==WAIT). This is a registered state decode with no combinational path from inputs.
- WAIT: if validTri_R13H, latch tri, color, box and step.
  - Degenerate box (ur_x<ll_x or ur_y<ll_y): consumed, stay in WAIT, emit nothing.
  - Otherwise: cur=(ll_x,ll_y), go to TEST.
- TEST, each cycle:
  - Emit lane i: x = cur_x + i*step, y = cur_y.
  - validSamp[i] = (x <= ur_x). y is always within the box in TEST.
  - Advance: nx = cur_x + SAMPS*step.
    - If nx <= ur_x: cur_x = nx.
    - Else if cur_y+step <= ur_y: cur_x = ll_x, cur_y += step.
    - Else: go to WAIT.
- Sample outputs are registered. Samples for cur appear on _R14 the cycle after the state holds cur. The first sample group is valid the cycle after accept.
- After the last group, halt_R13L=1 one cycle later. This gives exactly one bubble cycle between back-to-back triangles.
- Arithmetic: compares/additions in SIGFIG+1 signed to avoid wrap near the screen edge. Lanes with x overflow are invalid.
- WAIT output cycles: validSamp all 0. tri/color/sample hold their last value.
- Reset values: state=WAIT, halt_R13L=1, validSamp all 0, sample/tri/color all 0.
- Reset mid-TEST: the next cycle is WAIT with all outputs at reset values. The partially iterated triangle is dropped.
- validTri_R13H during TEST: ignored; upstream holds it because halt_R13L=0.

Optional Feature:
- Macro: SAMPLE_ITERATOR_STATS_EN.
- When defined, adds outputs:
  - triCount_RnnU, 32b: triangles accepted, including degenerate ones.
  - sampCount_RnnU, 32b: sum of valid lanes emitted.
- Both counters clear on rst and wrap at 2^32.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Shared package rast_pkg holds:
  - typedef for the iterator state enum;
  - subsample one-hot constants and the step decode function;
  - box index constants LL=0, UR=1, X=0, Y=1.
- One natural sub-module: sample_iter_lane_gen. It is combinational and computes the SAMPS lane x values and valid bits from cur_x, step and ur_x. It is instantiated once.

Test Plan:
- Full 4x2 box: box ll=(0,0), ur=(3072,1024), subSample=1000 → accept cycle 0; cycle 1: x={0,1024,2048,3072}, y=0, valid=1111; cycle 2: y=1024, valid=1111; cycle 3: valid=0000, halt_R13L=1.
- Partial row: ur=(1024,0) → one cycle, valid=1100, x={0,1024,…}; then WAIT.
- 4xMSAA: subSample=0100, ll=(0,0), ur=(512,512) → y=0 valid=1100, then y=512 valid=1100, then WAIT.
- Degenerate box: ll=(2048,0), ur=(1024,0) → halt_R13L stays 1, no valid lanes; with STATS_EN, triCount +1 and sampCount +0.
- Back-to-back: validTri held high with two 1-group triangles → second accepted exactly 2 cycles after the first; one bubble observed.
- Reset mid-TEST: rst asserted in the 2nd iteration cycle of a 3-row box → next cycle valid=0000, halt_R13L=1, sample=0; new triangle accepted normally afterwards.
